// File: rtl/ysyx_24090012_scoreboard.sv
// In-order issue scoreboard: tracks in-flight instructions in a small FIFO
// and stalls issue on read-after-write hazards against pending writers.
module ysyx_24090012_scoreboard #(
  parameter int DEPTH  = 4,
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_use_rs1,
  input  logic        issue_use_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_wen,
  input  logic        issue_is_load,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [31:0] busy_vec,
  output logic [31:0] load_busy_vec,
  output logic [3:0]  inflight_cnt,
  output logic [31:0] stall_cycles,
  output logic        sb_err
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    head, tail;
  logic [3:0]       cnt;
  logic [4:0]       rd_q [DEPTH];
  logic [DEPTH-1:0] wen_q, ld_q, slot_vld;
  logic [31:0]      busy, lbusy, blk;
  logic             hazard, full, push, pop, wen_eff;

  // A slot is live when its distance from head is below the occupancy count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] off;
    assign off         = PW'(g) - head;
    assign slot_vld[g] = 4'(off) < cnt;
  end

  // Rebuild the busy masks from live queue entries every cycle.
  always_comb begin
    busy  = '0;
    lbusy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i] && wen_q[i]) begin
        busy[rd_q[i]] = 1'b1;
        if (ld_q[i]) lbusy[rd_q[i]] = 1'b1;
      end
    end
  end

  // Hazard check and handshake; only registered state feeds issue_ready, so a
  // same-cycle writeback cannot open a slot or clear a hazard.
  always_comb begin
    blk     = FWD_EN ? lbusy : busy;
    hazard  = (issue_use_rs1 && (issue_rs1 != 5'd0) && blk[issue_rs1]) ||
              (issue_use_rs2 && (issue_rs2 != 5'd0) && blk[issue_rs2]);
    full    = cnt >= 4'(DEPTH);
    wen_eff = issue_rd_wen && (issue_rd != 5'd0);
    push    = issue_valid && !full && !hazard;
    pop     = wb_valid && (cnt != 4'd0);
  end

  assign issue_ready   = !full && !hazard;
  assign busy_vec      = busy;
  assign load_busy_vec = lbusy;
  assign inflight_cnt  = cnt;

  // Queue, occupancy, stall counter and sticky error update.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      wen_q        <= '0;
      ld_q         <= '0;
      stall_cycles <= '0;
      sb_err       <= 1'b0;
    end else begin
      if (push) begin
        rd_q[tail]  <= issue_rd;
        wen_q[tail] <= wen_eff;
        ld_q[tail]  <= issue_is_load;
        tail        <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
      if (issue_valid && !issue_ready) stall_cycles <= stall_cycles + 32'd1;
      if (wb_valid && (cnt == 4'd0)) sb_err <= 1'b1;
      if (pop && wen_q[head] && (rd_q[head] != wb_rd)) sb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_24090012_scoreboard.sv
// Randomized scoreboard bench: two DUTs (forwarding on/off) share stimulus;
// a queue-based reference model predicts each cycle's outputs, a monitor
// compares them on the falling edge.
module tb_ysyx_24090012_scoreboard;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0] rd;
    logic       wen;
    logic       ld;
  } ent_t;

  typedef struct packed {
    logic        rdy;
    logic [31:0] busy;
    logic [31:0] lbusy;
    logic [3:0]  cnt;
    logic [31:0] stall;
    logic        err;
  } obs_t;

  logic clock = 1'b0;
  logic reset;
  logic iv, u1, u2, wen, ld, wbv;
  logic [4:0] rs1, rs2, rd, wbrd;

  logic        rdy   [2];
  logic [31:0] busy  [2];
  logic [31:0] lbusy [2];
  logic [3:0]  cnt   [2];
  logic [31:0] stall [2];
  logic        err   [2];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ysyx_24090012_scoreboard #(.DEPTH(DEPTH), .FWD_EN(1'b1)) dut_fwd (
    .clock(clock), .reset(reset), .issue_valid(iv), .issue_ready(rdy[0]),
    .issue_rs1(rs1), .issue_rs2(rs2), .issue_use_rs1(u1), .issue_use_rs2(u2),
    .issue_rd(rd), .issue_rd_wen(wen), .issue_is_load(ld),
    .wb_valid(wbv), .wb_rd(wbrd), .busy_vec(busy[0]), .load_busy_vec(lbusy[0]),
    .inflight_cnt(cnt[0]), .stall_cycles(stall[0]), .sb_err(err[0]));

  ysyx_24090012_scoreboard #(.DEPTH(DEPTH), .FWD_EN(1'b0)) dut_nofwd (
    .clock(clock), .reset(reset), .issue_valid(iv), .issue_ready(rdy[1]),
    .issue_rs1(rs1), .issue_rs2(rs2), .issue_use_rs1(u1), .issue_use_rs2(u2),
    .issue_rd(rd), .issue_rd_wen(wen), .issue_is_load(ld),
    .wb_valid(wbv), .wb_rd(wbrd), .busy_vec(busy[1]), .load_busy_vec(lbusy[1]),
    .inflight_cnt(cnt[1]), .stall_cycles(stall[1]), .sb_err(err[1]));

  // Reference model state per instance (0 = forwarding, 1 = no forwarding).
  ent_t        mq [2][$];
  logic [31:0] m_stall [2];
  logic        m_err [2];
  obs_t        expq [$];

  // Set of registers with a pending writer (optionally loads only).
  function automatic logic [31:0] pend(int k, bit loads_only);
    logic [31:0] v = '0;
    foreach (mq[k][j])
      if (mq[k][j].wen && (!loads_only || mq[k][j].ld)) v[mq[k][j].rd] = 1'b1;
    return v;
  endfunction

  function automatic logic m_ready(int k);
    logic [31:0] b = pend(k, k == 0);
    logic hz = (u1 && rs1 != 0 && b[rs1]) || (u2 && rs2 != 0 && b[rs2]);
    return (mq[k].size() < DEPTH) && !hz;
  endfunction

  function automatic obs_t m_obs(int k);
    obs_t o;
    o.rdy   = m_ready(k);
    o.busy  = pend(k, 1'b0);
    o.lbusy = pend(k, 1'b1);
    o.cnt   = 4'(mq[k].size());
    o.stall = m_stall[k];
    o.err   = m_err[k];
    return o;
  endfunction

  // Apply one clock edge to the model with the current inputs.
  task automatic m_edge(int k);
    logic r = m_ready(k);
    ent_t e;
    if (!reset) begin
      mq[k].delete();
      m_stall[k] = 0;
      m_err[k]   = 1'b0;
      return;
    end
    if (iv && !r) m_stall[k] = m_stall[k] + 1;
    if (wbv) begin
      if (mq[k].size() == 0) m_err[k] = 1'b1;
      else begin
        e = mq[k].pop_front();
        if (e.wen && e.rd != wbrd) m_err[k] = 1'b1;
      end
    end
    if (iv && r) begin
      e.rd = rd; e.wen = wen && (rd != 0); e.ld = ld;
      mq[k].push_back(e);
    end
  endtask

  // Drive one cycle of inputs, record expectations, advance model on the edge.
  task automatic step(input logic rst_n, input logic v, input logic [4:0] a,
                      input logic [4:0] b, input logic ua, input logic ub,
                      input logic [4:0] d, input logic w, input logic l,
                      input logic wv, input logic [4:0] wr);
    reset = rst_n; iv = v; rs1 = a; rs2 = b; u1 = ua; u2 = ub;
    rd = d; wen = w; ld = l; wbv = wv; wbrd = wr;
    expq.push_back(m_obs(0));
    expq.push_back(m_obs(1));
    @(posedge clock);
    m_edge(0);
    m_edge(1);
    #1;
  endtask

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t got=%h want=%h", name, k, $time, act, exp);
    end
  endtask

  // Monitor: compare each DUT against the oldest pending expectation.
  always @(negedge clock) begin
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("issue_ready",   k, 32'(rdy[k]),   32'(e.rdy));
        chk("busy_vec",      k, busy[k],       e.busy);
        chk("load_busy_vec", k, lbusy[k],      e.lbusy);
        chk("inflight_cnt",  k, 32'(cnt[k]),   32'(e.cnt));
        chk("stall_cycles",  k, stall[k],      e.stall);
        chk("sb_err",        k, 32'(err[k]),   32'(e.err));
      end
    end
  end

  initial begin
    logic [4:0] hr;
    for (int k = 0; k < 2; k++) begin m_stall[k] = 0; m_err[k] = 1'b0; end
    reset = 1'b0; iv = 0; u1 = 0; u2 = 0; wen = 0; ld = 0; wbv = 0;
    rs1 = 0; rs2 = 0; rd = 0; wbrd = 0;
    @(posedge clock); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use: lw x5 then add x6,x5,x1 held until the load retires
    step(1, 1, 0, 0, 1, 0, 5, 1, 1, 0, 0);
    repeat (3) step(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    step(1, 1, 5, 1, 1, 1, 6, 1, 0, 1, 5);
    step(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    // ALU dependency: addi x7 then add x8,x7,x7
    step(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    repeat (2) step(1, 1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    repeat (2) step(1, 1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // full queue, fifth issue with same-cycle writeback, then accepted
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 5'(10 + i), 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 20, 1, 0, 1, 10);
    step(1, 1, 0, 0, 0, 0, 20, 1, 0, 0, 0);
    // reset with a full queue and simultaneous issue/writeback
    step(0, 1, 0, 0, 0, 0, 21, 1, 0, 1, 11);
    // two lw x9 in flight, retired one at a time
    step(1, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    // errors: empty-queue writeback, then rd mismatch after reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // random traffic over a small register set so hazards are frequent
    for (int n = 0; n < 4000; n++) begin
      hr = (mq[0].size() > 0) ? mq[0][0].rd : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) hr = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 249) != 0),
           ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom),
           5'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), hr);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL monitor_drain left=%0d want=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_24090012_scoreboard.md
YSYX_24090012_SCOREBOARD -- requirements
Module: ysyx_24090012_scoreboard

Interface
REQ-001 Parameter DEPTH, default 4: in-flight queue entries, power of two, 2..8.
REQ-002 Parameter FWD_EN, default 1: 1 means only pending loads block, 0 means any pending writer blocks.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-005 issue_valid  in  1  IDU presents a decoded instruction.
REQ-006 issue_ready  out  1  scoreboard accepts it this cycle.
REQ-007 issue_rs1, issue_rs2  in  5 each  source register indices.
REQ-008 issue_use_rs1, issue_use_rs2  in  1 each  source operand is actually read.
REQ-009 issue_rd  in  5  destination register index.
REQ-010 issue_rd_wen  in  1  instruction writes rd.
REQ-011 issue_is_load  in  1  instruction is a load (opcode 0000011).
REQ-012 wb_valid  in  1  WBU retires the oldest in-flight instruction this cycle.
REQ-013 wb_rd  in  5  rd of the retiring instruction, for checking.
REQ-014 busy_vec  out  32  bit i set while any in-flight writer of xi exists.
REQ-015 load_busy_vec  out  32  bit i set while any in-flight load writes xi.
REQ-016 inflight_cnt  out  4  number of queue entries occupied.
REQ-017 stall_cycles  out  32  cycles in which issue_valid=1 and issue_ready=0.
REQ-018 sb_err  out  1  sticky protocol-error flag.

Function
REQ-019 The block SHALL hold an in-order FIFO of DEPTH entries, each holding {rd, wen_eff, is_load}, where wen_eff = issue_rd_wen AND (issue_rd != 0).
REQ-020 The block SHALL compute hazard = (use_rs1 AND rs1 != 0 AND blk[rs1]) OR (use_rs2 AND rs2 != 0 AND blk[rs2]).
REQ-021 blk SHALL equal load_busy_vec when FWD_EN=1, and busy_vec when FWD_EN=0.
REQ-022 issue_ready SHALL equal (inflight_cnt < DEPTH) AND NOT hazard. It is combinational and uses only registered state.
REQ-023 A same-cycle wb_valid SHALL NOT relax issue_ready: no full bypass and no hazard bypass.
REQ-024 When issue_valid AND issue_ready, the block SHALL enqueue at the tail on that posedge. Entries with wen_eff=0 are still enqueued, to preserve retire order.
REQ-025 When wb_valid and the queue is non-empty, the block SHALL pop the head on that posedge.
REQ-026 If the popped entry has wen_eff=1 and its rd differs from wb_rd, the block SHALL set sb_err.
REQ-027 If wb_valid arrives with the queue empty, the block SHALL ignore it and set sb_err.
REQ-028 Simultaneous enqueue and pop SHALL leave inflight_cnt unchanged, and both updates SHALL take effect.
REQ-029 busy_vec and load_busy_vec SHALL be derived from the valid entries after the update (registered or recomputed from the queue). They are visible in the cycle after the enqueue or pop.
REQ-030 Multiple in-flight writers of the same rd SHALL keep busy set until the last one retires.
REQ-031 The head and tail pointers SHALL wrap modulo DEPTH, and full/empty SHALL be distinguished by inflight_cnt.
REQ-032 stall_cycles SHALL increment by 1 in each cycle with issue_valid=1 and issue_ready=0, and SHALL wrap at 2^32.
REQ-033 sb_err SHALL remain set until reset.
REQ-034 issue_valid=0 SHALL never enqueue, regardless of issue_ready.

Reset
REQ-035 With reset=0 at a posedge, the block SHALL clear the queue, inflight_cnt, busy_vec, load_busy_vec, stall_cycles and sb_err to 0. issue_ready then reads 1.
REQ-036 Reset SHALL override simultaneous issue and wb_valid, including mid-operation with a full queue; no entry survives.

Verification
REQ-037 Load-use: issue lw x5 (accepted); next cycle issue add x6,x5,x1 -> issue_ready=0 and stall_cycles increments each cycle. wb_valid with wb_rd=5 -> add accepted the following cycle.
REQ-038 FWD_EN=1, ALU dependency: addi x7; then add x8,x7,x7 -> issue_ready=1 immediately. The same sequence with FWD_EN=0 -> stall until addi retires.
REQ-039 Full queue: DEPTH=4, four non-dependent issues with no retire -> inflight_cnt=4 and issue_ready=0. A fifth issue with a same-cycle wb_valid -> rejected; accepted the next cycle with inflight_cnt=4.
REQ-040 Multiple writers: two lw x9 in flight, then retire the first -> load_busy_vec[9] stays 1; retire the second -> 0.
REQ-041 Errors: wb_valid on an empty queue -> sb_err=1 and inflight_cnt stays 0. Separately, head rd=3 retired with wb_rd=4 -> sb_err=1.
REQ-042 Reset mid-run: queue at 3 entries and stall_cycles=10, reset=0 for one cycle -> all outputs 0 and issue_ready=1.
